// File: rtl/prbs_checker.sv
// prbs_checker: serial PRBS checker on the recovered-clock side of the link.
// Self-synchronises a local LFSR (x^LEN + x^TAP + 1) to the received
// stream, then counts checked bits and bit errors for BER measurement.
// Loss of lock is declared when UNLOCK_THR errors land inside one window
// of ERR_WIN checked bits; re-acquisition is automatic.
//
// Ports:
//   clk      recovered clock, data sampled on rising edge
//   rstb     asynchronous active-low reset
//   en       bit valid; all state and counters hold when low
//   data     retimed received bit
//   clr      synchronous clear of err_cnt / bit_cnt (independent of en)
//   lock     pattern locked
//   err      one-cycle pulse per mismatched bit while locked
//   err_cnt  saturating error count
//   bit_cnt  saturating checked-bit count
//
// state  | meaning
// SEED   | loading LEN received bits into the LFSR
// VERIFY | LFSR fed from line, counting consecutive predicted matches
// LOCKED | LFSR free-running, comparing and counting errors
module prbs_checker #(
  parameter int LEN        = 21,
  parameter int TAP        = 19,
  parameter int INV        = 0,
  parameter int LOCK_CNT   = 64,
  parameter int ERR_WIN    = 1024,
  parameter int UNLOCK_THR = 16,
  parameter int CNT_W      = 32
) (
  input  logic             clk,
  input  logic             rstb,
  input  logic             en,
  input  logic             data,
  input  logic             clr,
  output logic             lock,
  output logic             err,
  output logic [CNT_W-1:0] err_cnt,
  output logic [CNT_W-1:0] bit_cnt
);

  localparam int   SEED_W  = $clog2(LEN + 1);
  localparam int   MATCH_W = $clog2(LOCK_CNT + 1);
  localparam int   WIN_W   = $clog2(ERR_WIN + 1);
  localparam int   WERR_W  = $clog2(UNLOCK_THR + 1);
  localparam logic INV_B   = (INV != 0);

  typedef enum logic [1:0] {SEED, VERIFY, LOCKED} state_t;

  state_t             state, state_nxt;
  logic [LEN-1:0]     sr, sr_nxt;
  logic [SEED_W-1:0]  seed_cnt, seed_nxt;
  logic [MATCH_W-1:0] match_cnt, match_nxt;
  logic [WIN_W-1:0]   win_cnt, win_nxt;
  logic [WERR_W-1:0]  win_err, werr_nxt;
  logic               err_nxt, bit_inc, err_inc;

  logic           d, pred, mismatch, zero_in, seed_last, match_last;
  logic           unlock_hit, win_last;
  logic [LEN-1:0] sr_in;

  assign d          = data ^ INV_B;
  assign pred       = sr[LEN-1] ^ sr[TAP-1];
  assign mismatch   = d ^ pred;
  assign sr_in      = {sr[LEN-2:0], d};
  assign zero_in    = (sr_in == '0);
  assign seed_last  = (seed_cnt == SEED_W'(LEN - 1));
  assign match_last = (match_cnt == MATCH_W'(LOCK_CNT - 1));
  // Window error count is cleared on every rollover, so it never passes THR-1 here.
  assign unlock_hit = mismatch && (win_err == WERR_W'(UNLOCK_THR - 1));
  assign win_last   = (win_cnt == WIN_W'(ERR_WIN - 1));

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) state <= SEED;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (en) begin
      case (state)
        SEED:    if (seed_last && !zero_in) state_nxt = VERIFY;
        VERIFY: begin
          if (mismatch || zero_in) state_nxt = SEED;
          else if (match_last)     state_nxt = LOCKED;
        end
        LOCKED:  if (unlock_hit) state_nxt = SEED;
        default: state_nxt = SEED;
      endcase
    end
  end

  always_comb begin
    sr_nxt    = sr;
    seed_nxt  = seed_cnt;
    match_nxt = match_cnt;
    win_nxt   = win_cnt;
    werr_nxt  = win_err;
    err_nxt   = 1'b0;
    bit_inc   = 1'b0;
    err_inc   = 1'b0;
    if (en) begin
      case (state)
        SEED: begin
          sr_nxt    = sr_in;
          seed_nxt  = seed_last ? '0 : seed_cnt + 1'b1;
          match_nxt = '0;
        end
        VERIFY: begin
          sr_nxt = sr_in;
          if (mismatch || zero_in || match_last) match_nxt = '0;
          else                                   match_nxt = match_cnt + 1'b1;
          seed_nxt = '0;
          win_nxt  = '0;
          werr_nxt = '0;
        end
        LOCKED: begin
          // Reference free-runs so one line error costs exactly one err pulse.
          sr_nxt  = {sr[LEN-2:0], pred};
          err_nxt = mismatch;
          bit_inc = 1'b1;
          err_inc = mismatch;
          if (unlock_hit || win_last) begin
            win_nxt  = '0;
            werr_nxt = '0;
          end else begin
            win_nxt  = win_cnt + 1'b1;
            werr_nxt = win_err + WERR_W'(mismatch);
          end
          if (unlock_hit) seed_nxt = '0;
        end
        default: ;
      endcase
    end
  end

  assign lock = (state == LOCKED);

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      sr        <= '0;
      seed_cnt  <= '0;
      match_cnt <= '0;
      win_cnt   <= '0;
      win_err   <= '0;
      err       <= 1'b0;
      err_cnt   <= '0;
      bit_cnt   <= '0;
    end else begin
      sr        <= sr_nxt;
      seed_cnt  <= seed_nxt;
      match_cnt <= match_nxt;
      win_cnt   <= win_nxt;
      win_err   <= werr_nxt;
      err       <= err_nxt;
      // clr wins over a coincident increment; err still pulses.
      if (clr) begin
        err_cnt <= '0;
        bit_cnt <= '0;
      end else begin
        if (bit_inc && (bit_cnt != '1)) bit_cnt <= bit_cnt + 1'b1;
        if (err_inc && (err_cnt != '1)) err_cnt <= err_cnt + 1'b1;
      end
    end
  end

endmodule
